hash_msg_padder: RTL

//  Front-end padding stage for the MD5/SHA-1/SHA-2 compression cores. Accepts a byte stream per message,

---
 rtl/hash_pad_pkg.sv | 30 +++
 rtl/hash_msg_padder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hash_pad_pkg.sv
// Shared types and helpers for the hash message padder: FSM state encoding
// and the message-length field formatter.
package hash_pad_pkg;

   typedef enum logic [2:0] {
      FILL,
      PAD,
      ZERO,
      LEN,
      OUT
   } pad_state_e;

   // Returns the length field in the low len_bytes*8 bits, earliest block byte
   // at the most significant end of that slice.
   function automatic logic [127:0] len_field(input logic [124:0] count,
                                              input logic         big_endian,
                                              input int           len_bytes);
      logic [127:0] bits;
      logic [127:0] res;
      bits = {count, 3'b000};
      res  = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < len_bytes) begin
            res[i*8 +: 8] = big_endian ? bits[i*8 +: 8] : bits[(len_bytes-1-i)*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hash_msg_padder.sv
// MD5/SHA padding front end: buffers one block, appends 0x80, zero fill and the
// bit length. Optional input abort is enabled by defining HASH_PAD_ABORT_EN.
module hash_msg_padder
   import hash_pad_pkg::*;
#(
   parameter int BLOCK_BYTES    = 64,
   parameter bit LEN_BIG_ENDIAN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef HASH_PAD_ABORT_EN
   input  logic                     abort,
`endif
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   input  logic                     in_empty,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BLOCK_BYTES*8-1:0] out_block,
   output logic                     out_last
);

   localparam int LEN_BYTES = BLOCK_BYTES / 8;
   localparam int IDX_W     = $clog2(BLOCK_BYTES);
   localparam int CNT_W     = (BLOCK_BYTES == 128) ? 125 : 64;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_LEN  = IDX_W'(BLOCK_BYTES - LEN_BYTES);

   pad_state_e                 state;
   pad_state_e                 ret;
   logic [IDX_W-1:0]           idx;
   logic [CNT_W-1:0]           count;
   logic [IDX_W+2:0]           wr_lsb;
   logic [8*LEN_BYTES-1:0]     len_bits;
   logic                       take_byte;
   logic                       take_tail;
   logic                       abort_req;

`ifdef HASH_PAD_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Byte 0 lives at the MSBs, so buffer position idx maps to bit (LAST-idx)*8.
   assign wr_lsb    = {IDX_LAST - idx, 3'b000};
   assign len_bits  = (8*LEN_BYTES)'(len_field(125'(count), LEN_BIG_ENDIAN, LEN_BYTES));
   assign take_byte = in_valid && in_ready && !(in_last && in_empty);
   assign take_tail = in_valid && in_ready && in_last && in_empty;

   // NOTE: all state, including the block buffer, updates with non-blocking
   // assignments in one clocked block; the buffer is reset because out_block
   // has a defined reset value.
   always_ff @(posedge clk) begin
      if (rst || abort_req) begin
         state     <= FILL;
         ret       <= FILL;
         idx       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         in_ready  <= !rst;
         if (rst) begin
            out_block <= '0;
         end
      end else begin
         unique case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (take_byte) begin
                  out_block[wr_lsb +: 8] <= in_data;
                  idx   <= idx + 1'b1;
                  count <= count + 1'b1;
                  if (idx == IDX_LAST) begin
                     state     <= OUT;
                     ret       <= in_last ? PAD : FILL;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                     in_ready  <= 1'b0;
                  end else if (in_last) begin
                     state    <= PAD;
                     in_ready <= 1'b0;
                  end
               end else if (take_tail) begin
                  state    <= PAD;
                  in_ready <= 1'b0;
               end
            end
            PAD: begin
               out_block[wr_lsb +: 8] <= 8'h80;
               idx <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  state     <= OUT;
                  ret       <= ZERO;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
               end else begin
                  state <= ZERO;
               end
            end
            ZERO: begin
               if (idx == IDX_LEN) begin
                  state <= LEN;
               end else begin
                  out_block[wr_lsb +: 8] <= 8'h00;
                  idx <= idx + 1'b1;
                  if (idx == IDX_LAST) begin
                     state     <= OUT;
                     ret       <= ZERO;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                  end
               end
            end
            LEN: begin
               out_block[8*LEN_BYTES-1:0] <= len_bits;
               state     <= OUT;
               out_valid <= 1'b1;
               out_last  <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= '0;
                  if (out_last) begin
                     out_last <= 1'b0;
                     count    <= '0;
                     ret      <= FILL;
                     state    <= FILL;
                     in_ready <= 1'b1;
                  end else begin
                     state    <= ret;
                     in_ready <= (ret == FILL);
                  end
               end
            end
            default: begin
               state    <= FILL;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
